// File: rtl/pwm_duty_shadow_bank.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_duty_shadow_bank
//  Purpose  : Multi-channel double-buffered duty-cycle register bank. Writes
//             land in per-channel shadow registers; active duties update only
//             on an unlocked period_end strobe, so the PWM comparator never
//             sees a mid-period duty change.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_duty_shadow_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              c_CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [c_CW-1:0]           wr_ch,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      period_end,
    input  logic                      lock,
    output logic [CHANNELS*WIDTH-1:0] active_data,
    output logic [CHANNELS-1:0]       pending,
    output logic                      commit_pulse,
    output logic                      err
);

    // Architectural state
    logic [WIDTH-1:0]          r_shadow_q [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] r_active_q;
    logic [CHANNELS-1:0]       r_pending_q;
    logic                      r_pulse_q;
    logic                      r_err_q;

    // Next-state values
    logic [WIDTH-1:0]          w_shadow_d [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] w_active_d;
    logic [CHANNELS-1:0]       w_pending_d;
    logic                      w_pulse_d;
    logic                      w_err_d;

    logic w_accept;
    logic w_commit;
    logic w_in_range;

    // Lock gates both the write handshake and the commit strobe
    assign wr_ready   = ~lock;
    assign w_accept   = wr_valid & ~lock;
    assign w_commit   = period_end & ~lock;
    assign w_in_range = (32'(wr_ch) < 32'(CHANNELS));

    // Next-state: commit reads the old shadow/pending, then a same-edge write
    // overrides shadow and re-arms pending so it waits for the next period.
    always_comb begin
        w_shadow_d  = r_shadow_q;
        w_active_d  = r_active_q;
        w_pending_d = r_pending_q;
        w_err_d     = r_err_q;
        w_pulse_d   = w_commit & (|r_pending_q);

        if (w_commit) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_pending_q[i]) begin
                    w_active_d[i*WIDTH +: WIDTH] = r_shadow_q[i];
                    w_pending_d[i]               = 1'b0;
                end
            end
        end

        if (w_accept) begin
            if (w_in_range) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (wr_ch == c_CW'(i)) begin
                        w_shadow_d[i]  = wr_data;
                        w_pending_d[i] = 1'b1;
                    end
                end
            end else begin
                w_err_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset taking priority over all traffic
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow_q[i] <= RESET_VAL;
            end
            r_active_q  <= {CHANNELS{RESET_VAL}};
            r_pending_q <= '0;
            r_pulse_q   <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_shadow_q  <= w_shadow_d;
            r_active_q  <= w_active_d;
            r_pending_q <= w_pending_d;
            r_pulse_q   <= w_pulse_d;
            r_err_q     <= w_err_d;
        end
    end

    assign active_data  = r_active_q;
    assign pending      = r_pending_q;
    assign commit_pulse = r_pulse_q;
    assign err          = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_shadow_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_duty_shadow_bank
//  Purpose  : Directed vector bench for pwm_duty_shadow_bank (4-channel bank
//             driven from a table, 3-channel bank for out-of-range writes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_duty_shadow_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        a_rst, a_wv, a_pe, a_lk, a_rdy, a_pulse, a_err;
    logic [1:0]  a_ch;
    logic [7:0]  a_d;
    logic [31:0] a_act;
    logic [3:0]  a_pend;

    // 3-channel instance
    logic        b_rst, b_wv, b_pe, b_lk, b_rdy, b_pulse, b_err;
    logic [1:0]  b_ch;
    logic [7:0]  b_d;
    logic [23:0] b_act;
    logic [2:0]  b_pend;

    pwm_duty_shadow_bank #(.WIDTH(8), .CHANNELS(4), .RESET_VAL(8'h00)) u_dut_a (
        .ck(clk), .rst(a_rst), .wr_valid(a_wv), .wr_ready(a_rdy), .wr_ch(a_ch),
        .wr_data(a_d), .period_end(a_pe), .lock(a_lk), .active_data(a_act),
        .pending(a_pend), .commit_pulse(a_pulse), .err(a_err)
    );

    pwm_duty_shadow_bank #(.WIDTH(8), .CHANNELS(3), .RESET_VAL(8'h00)) u_dut_b (
        .ck(clk), .rst(b_rst), .wr_valid(b_wv), .wr_ready(b_rdy), .wr_ch(b_ch),
        .wr_data(b_d), .period_end(b_pe), .lock(b_lk), .active_data(b_act),
        .pending(b_pend), .commit_pulse(b_pulse), .err(b_err)
    );

    typedef struct {
        logic        rst;
        logic        wv;
        logic [1:0]  ch;
        logic [7:0]  d;
        logic        pe;
        logic        lk;
        logic [31:0] e_act;
        logic [3:0]  e_pend;
        logic        e_pulse;
        logic        e_rdy;
    } vec_t;

    localparam int c_NVEC = 21;
    vec_t vecs [c_NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive channel B inputs on the falling edge, then sample 1ns after the rising edge
    task automatic b_step(input logic rst_i, input logic wv, input logic [1:0] ch,
                          input logic [7:0] d, input logic pe);
        @(negedge clk);
        b_rst = rst_i; b_wv = wv; b_ch = ch; b_d = d; b_pe = pe; b_lk = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst  wv  ch     d      pe   lk   active         pend     pulse rdy
        // reset
        vecs[0]  = '{1'b1,1'b0,2'd0,8'h00,1'b0,1'b0,32'h0000_0000,4'b0000,1'b0,1'b1};
        // write ch2=80, then commit
        vecs[1]  = '{1'b0,1'b1,2'd2,8'h80,1'b0,1'b0,32'h0000_0000,4'b0100,1'b0,1'b1};
        vecs[2]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,32'h0080_0000,4'b0000,1'b1,1'b1};
        vecs[3]  = '{1'b0,1'b0,2'd0,8'h00,1'b0,1'b0,32'h0080_0000,4'b0000,1'b0,1'b1};
        // same-edge write and commit on ch1
        vecs[4]  = '{1'b0,1'b1,2'd1,8'h10,1'b0,1'b0,32'h0080_0000,4'b0010,1'b0,1'b1};
        vecs[5]  = '{1'b0,1'b1,2'd1,8'h20,1'b1,1'b0,32'h0080_1000,4'b0010,1'b1,1'b1};
        vecs[6]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,32'h0080_2000,4'b0000,1'b1,1'b1};
        // period_end with nothing pending
        vecs[7]  = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,32'h0080_2000,4'b0000,1'b0,1'b1};
        // lock: pending ch0 retained, write refused, strobe ignored
        vecs[8]  = '{1'b0,1'b1,2'd0,8'h55,1'b0,1'b0,32'h0080_2000,4'b0001,1'b0,1'b1};
        vecs[9]  = '{1'b0,1'b1,2'd0,8'hAA,1'b0,1'b1,32'h0080_2000,4'b0001,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b1,32'h0080_2000,4'b0001,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,32'h0080_2055,4'b0000,1'b1,1'b1};
        // fill all four channels pending
        vecs[12] = '{1'b0,1'b1,2'd0,8'h01,1'b0,1'b0,32'h0080_2055,4'b0001,1'b0,1'b1};
        vecs[13] = '{1'b0,1'b1,2'd1,8'h02,1'b0,1'b0,32'h0080_2055,4'b0011,1'b0,1'b1};
        vecs[14] = '{1'b0,1'b1,2'd2,8'h03,1'b0,1'b0,32'h0080_2055,4'b0111,1'b0,1'b1};
        vecs[15] = '{1'b0,1'b1,2'd3,8'h04,1'b0,1'b0,32'h0080_2055,4'b1111,1'b0,1'b1};
        // reset with simultaneous strobe and write: everything discarded
        vecs[16] = '{1'b1,1'b1,2'd3,8'hFF,1'b1,1'b0,32'h0000_0000,4'b0000,1'b0,1'b1};
        vecs[17] = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,32'h0000_0000,4'b0000,1'b0,1'b1};
        // strobe held high across several cycles
        vecs[18] = '{1'b0,1'b1,2'd3,8'hFF,1'b1,1'b0,32'h0000_0000,4'b1000,1'b0,1'b1};
        vecs[19] = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,32'hFF00_0000,4'b0000,1'b1,1'b1};
        vecs[20] = '{1'b0,1'b0,2'd0,8'h00,1'b1,1'b0,32'hFF00_0000,4'b0000,1'b0,1'b1};

        a_rst = 1'b1; a_wv = 1'b0; a_ch = '0; a_d = '0; a_pe = 1'b0; a_lk = 1'b0;
        b_rst = 1'b1; b_wv = 1'b0; b_ch = '0; b_d = '0; b_pe = 1'b0; b_lk = 1'b0;

        // Table-driven run on the 4-channel bank
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            a_rst = vecs[i].rst; a_wv = vecs[i].wv; a_ch = vecs[i].ch;
            a_d   = vecs[i].d;   a_pe = vecs[i].pe; a_lk = vecs[i].lk;
            @(posedge clk);
            #1;
            chk("active_data",  i, a_act,               vecs[i].e_act);
            chk("pending",      i, {28'd0, a_pend},     {28'd0, vecs[i].e_pend});
            chk("commit_pulse", i, {31'd0, a_pulse},    {31'd0, vecs[i].e_pulse});
            chk("wr_ready",     i, {31'd0, a_rdy},      {31'd0, vecs[i].e_rdy});
            chk("err_a",        i, {31'd0, a_err},      32'd0);
        end

        // Out-of-range write on the 3-channel bank
        b_step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("b_reset_err",   100, {31'd0, b_err},  32'd0);
        b_step(1'b0, 1'b1, 2'd3, 8'h77, 1'b0);
        chk("b_oor_err",     101, {31'd0, b_err},  32'd1);
        chk("b_oor_pending", 101, {29'd0, b_pend}, 32'd0);
        b_step(1'b0, 1'b1, 2'd0, 8'h11, 1'b0);
        chk("b_err_sticky1", 102, {31'd0, b_err},  32'd1);
        chk("b_pending_ch0", 102, {29'd0, b_pend}, 32'd1);
        b_step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        chk("b_active",      103, {8'd0, b_act},   32'h0000_0011);
        chk("b_pulse",       103, {31'd0, b_pulse}, 32'd1);
        chk("b_err_sticky2", 103, {31'd0, b_err},  32'd1);
        b_step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("b_err_sticky3", 104, {31'd0, b_err},  32'd1);
        b_step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        chk("b_err_cleared", 105, {31'd0, b_err},  32'd0);
        chk("b_active_rst",  105, {8'd0, b_act},   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
